// File: rtl/renode_axi_pkg.sv
// -----------------------------------------------------------------------------
// renode_axi_pkg
// Shared AXI types and constants for the Renode AXI bridge blocks.
//   arbiter_state_e : read-arbiter FSM states
//   burst_size_t    : AXI AxSIZE
//   burst_length_t  : AXI AxLEN (beats - 1)
//   burst_type_e    : AXI AxBURST
//   response_e      : AXI xRESP
//   MaxBeats        : longest AXI4 burst in beats
// -----------------------------------------------------------------------------
package renode_axi_pkg;

  typedef enum logic [1:0] {
    Idle,
    Addr,
    Data
  } arbiter_state_e;

  typedef logic [2:0] burst_size_t;
  typedef logic [7:0] burst_length_t;

  typedef enum logic [1:0] {
    Fixed    = 2'b00,
    Incr     = 2'b01,
    Wrap     = 2'b10,
    Reserved = 2'b11
  } burst_type_e;

  typedef enum logic [1:0] {
    Okay   = 2'b00,
    ExOkay = 2'b01,
    SlvErr = 2'b10,
    DecErr = 2'b11
  } response_e;

  localparam int unsigned MaxBeats       = 256;
  // One extra bit so a full 256-beat burst count is representable.
  localparam int unsigned BeatCountWidth = $clog2(MaxBeats) + 1;

  // Number of data beats described by an AxLEN value.
  function automatic logic [BeatCountWidth-1:0] beats_in_burst(input burst_length_t len);
    return {1'b0, len} + BeatCountWidth'(1);
  endfunction

endpackage

// File: rtl/renode_rr_arbiter.sv
// -----------------------------------------------------------------------------
// renode_rr_arbiter
// Round-robin picker: combinationally selects the first asserted request
// scanning upward from the requester after last_grant, with wrap-around.
// last_grant is registered and updated when the caller commits a pick.
// Ports:
//   aclk, areset : clock, synchronous active-high reset (last_grant -> N-1,
//                  so requester 0 wins first)
//   request      : per-requester request vector
//   advance      : commit the current pick into last_grant
//   grant        : index of the picked requester
//   grant_valid  : at least one request is asserted
// -----------------------------------------------------------------------------
module renode_rr_arbiter #(
  parameter  int unsigned NumRequesters = 2,
  localparam int unsigned IndexWidth    = $clog2(NumRequesters)
) (
  input  logic                     aclk,
  input  logic                     areset,
  input  logic [NumRequesters-1:0] request,
  input  logic                     advance,
  output logic [IndexWidth-1:0]    grant,
  output logic                     grant_valid
);

  logic [IndexWidth-1:0] r_last_grant;
  int unsigned           w_scan;

  always_comb begin
    grant       = r_last_grant;
    grant_valid = 1'b0;
    w_scan      = 0;
    for (int unsigned k = 1; k <= NumRequesters; k++) begin
      w_scan = (int'(r_last_grant) + k) % NumRequesters;
      if (!grant_valid && request[IndexWidth'(w_scan)]) begin
        grant_valid = 1'b1;
        grant       = IndexWidth'(w_scan);
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_last_grant <= IndexWidth'(NumRequesters - 1);
    end else if (advance && grant_valid) begin
      r_last_grant <= grant;
    end
  end

endmodule

// File: rtl/renode_axi_read_arbiter.sv
// -----------------------------------------------------------------------------
// renode_axi_read_arbiter
// Shares one AXI read port (AR/R) between NumManagers read managers.
// Round-robin arbitration on AR, one outstanding burst at a time; R beats are
// steered to the granted manager until rlast. No ID remapping.
// Ports:
//   aclk, areset          : clock, synchronous active-high reset
//   m_ar*                 : per-manager AR channels, manager i at slice i
//   m_rvalid / m_rready   : per-manager R handshake
//   m_rdata/rid/rresp/rlast : broadcast copy of the subordinate R payload
//   s_ar* / s_r*          : single AR/R port towards the subordinate
//   grant_index           : current or most recent granted manager
//   protocol_error        : sticky flag, rlast disagreed with the beat count
// -----------------------------------------------------------------------------
module renode_axi_read_arbiter
  import renode_axi_pkg::*;
#(
  parameter  int unsigned NumManagers        = 2,
  parameter  int unsigned AddressWidth       = 32,
  parameter  int unsigned DataWidth          = 32,
  parameter  int unsigned TransactionIdWidth = 8,
  localparam int unsigned GrantWidth         = $clog2(NumManagers)
) (
  input  logic                                     aclk,
  input  logic                                     areset,

  input  logic [NumManagers-1:0]                   m_arvalid,
  output logic [NumManagers-1:0]                   m_arready,
  input  logic [NumManagers*AddressWidth-1:0]      m_araddr,
  input  logic [NumManagers*TransactionIdWidth-1:0] m_arid,
  input  logic [NumManagers*8-1:0]                 m_arlen,
  input  logic [NumManagers*3-1:0]                 m_arsize,
  input  logic [NumManagers*2-1:0]                 m_arburst,

  output logic [NumManagers-1:0]                   m_rvalid,
  input  logic [NumManagers-1:0]                   m_rready,
  output logic [DataWidth-1:0]                     m_rdata,
  output logic [TransactionIdWidth-1:0]            m_rid,
  output logic [1:0]                               m_rresp,
  output logic                                     m_rlast,

  output logic                                     s_arvalid,
  output logic [AddressWidth-1:0]                  s_araddr,
  output logic [TransactionIdWidth-1:0]            s_arid,
  output burst_length_t                            s_arlen,
  output burst_size_t                              s_arsize,
  output logic [1:0]                               s_arburst,
  input  logic                                     s_arready,

  input  logic                                     s_rvalid,
  input  logic [DataWidth-1:0]                     s_rdata,
  input  logic [TransactionIdWidth-1:0]            s_rid,
  input  logic [1:0]                               s_rresp,
  input  logic                                     s_rlast,
  output logic                                     s_rready,

  output logic [GrantWidth-1:0]                    grant_index,
  output logic                                     protocol_error
);

  arbiter_state_e              r_state;
  arbiter_state_e              w_state_next;

  logic [GrantWidth-1:0]       r_grant;
  logic [GrantWidth-1:0]       w_pick;
  logic                        w_pick_valid;
  logic                        w_arb_advance;
  burst_length_t               w_pick_arlen;

  logic [BeatCountWidth-1:0]   r_expected_beats;
  logic [BeatCountWidth-1:0]   r_beat_count;
  logic [BeatCountWidth-1:0]   w_beat_next;
  logic                        r_protocol_error;

  logic                        w_ar_hs;
  logic                        w_r_hs;

  // last_grant is committed when the pick is taken in Idle rather than when
  // the burst completes; it is only consulted in Idle and a reset clears it,
  // so the arbitration order is the same as updating it on rlast.
  assign w_arb_advance = (r_state == Idle);

  renode_rr_arbiter #(
    .NumRequesters(NumManagers)
  ) u_rr_arbiter (
    .aclk        (aclk),
    .areset      (areset),
    .request     (m_arvalid),
    .advance     (w_arb_advance),
    .grant       (w_pick),
    .grant_valid (w_pick_valid)
  );

  assign w_pick_arlen = m_arlen[w_pick*8 +: 8];

  // AR payload follows the registered grant; only the valid is state-gated.
  assign s_araddr  = m_araddr[r_grant*AddressWidth +: AddressWidth];
  assign s_arid    = m_arid[r_grant*TransactionIdWidth +: TransactionIdWidth];
  assign s_arlen   = m_arlen[r_grant*8 +: 8];
  assign s_arsize  = m_arsize[r_grant*3 +: 3];
  assign s_arburst = m_arburst[r_grant*2 +: 2];

  // R payload is broadcast; managers qualify it with their own m_rvalid.
  assign m_rdata = s_rdata;
  assign m_rid   = s_rid;
  assign m_rresp = s_rresp;
  assign m_rlast = s_rlast;

  assign w_ar_hs     = (r_state == Addr) && s_arvalid && s_arready;
  assign w_r_hs      = (r_state == Data) && s_rvalid && s_rready;
  assign w_beat_next = r_beat_count + BeatCountWidth'(1);

  assign grant_index    = r_grant;
  assign protocol_error = r_protocol_error;

  // State register
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_state <= Idle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      Idle:    if (w_pick_valid)       w_state_next = Addr;
      Addr:    if (w_ar_hs)            w_state_next = Data;
      Data:    if (w_r_hs && s_rlast)  w_state_next = Idle;
      default:                         w_state_next = Idle;
    endcase
  end

  // Output steering
  always_comb begin
    m_arready = '0;
    m_rvalid  = '0;
    s_arvalid = 1'b0;
    s_rready  = 1'b0;
    unique case (r_state)
      Addr: begin
        s_arvalid          = m_arvalid[r_grant];
        m_arready[r_grant] = s_arready;
      end
      Data: begin
        m_rvalid[r_grant] = s_rvalid;
        s_rready          = m_rready[r_grant];
      end
      default: ;
    endcase
  end

  // Grant, beat accounting and rlast consistency check
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_grant          <= GrantWidth'(NumManagers - 1);
      r_expected_beats <= '0;
      r_beat_count     <= '0;
      r_protocol_error <= 1'b0;
    end else begin
      if ((r_state == Idle) && w_pick_valid) begin
        r_grant          <= w_pick;
        r_expected_beats <= beats_in_burst(w_pick_arlen);
      end
      if (w_ar_hs) begin
        r_beat_count <= '0;
      end
      if (w_r_hs) begin
        if (r_beat_count != BeatCountWidth'(MaxBeats)) begin
          r_beat_count <= w_beat_next;
        end
        // Flags both an early rlast and a missing rlast on the final beat.
        if (s_rlast != (w_beat_next == r_expected_beats)) begin
          r_protocol_error <= 1'b1;
        end
      end
    end
  end

endmodule
